// File: rtl/aes256_pkg.sv
// AES-256 key expansion shared constants and FSM encoding.
// Rcon is indexed by i/8, so entry 0 is never used.
package aes256_pkg;

    localparam int NK = 8;
    localparam int NR = 14;
    localparam int NW = 60;

    localparam logic [7:0] RCON [8] = '{
        8'h00, 8'h01, 8'h02, 8'h04,
        8'h08, 8'h10, 8'h20, 8'h40
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational table lookup.
// Entry 0 sits in the most significant byte of the table.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] pos;

    assign pos = 11'h7ff - {a, 3'b000};
    assign y   = SBOX[pos -: 8];

endmodule

// File: rtl/aes256_key_expansion.sv
// AES-256 key schedule: one 32-bit word per cycle into a
// 60-word register store, round keys read out combinationally.
module aes256_key_expansion
    import aes256_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [255:0] key_i,
    input  logic [3:0]   round_num_i,
    output logic         key_exp_done_o,
    output logic         busy_o,
    output logic [127:0] round_key_o
);

    state_t      state;
    state_t      state_n;
    logic [5:0]  idx;
    logic [31:0] w [NW];
    logic        start_q;
    logic        armed;
    logic        start_edge;
    logic        load;
    logic [31:0] w_prev;
    logic [31:0] w_old;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] new_word;
    logic [5:0]  rk_base;

    // armed blocks a start_i that was already high when reset released
    assign start_edge = start_i & ~start_q & armed;
    assign load       = start_edge & (state != EXPAND);

    assign w_prev = w[idx - 6'd1];
    assign w_old  = w[idx - 6'd8];
    assign sub_in = (idx[2:0] == 3'd0)
                  ? {w_prev[23:0], w_prev[31:24]}
                  : w_prev;

    for (genvar g = 0; g < 4; g++) begin : g_sub
        aes_sbox u_sbox (
            .a (sub_in[8*g +: 8]),
            .y (sub_out[8*g +: 8])
        );
    end

    always_comb begin
        new_word = w_old ^ w_prev;
        unique case (1'b1)
            idx[2:0] == 3'd0:
                new_word = w_old ^ sub_out
                         ^ {RCON[idx[5:3]], 24'h0};
            idx[2:0] == 3'd4:
                new_word = w_old ^ sub_out;
            default:
                new_word = w_old ^ w_prev;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start_edge) state_n = EXPAND;
            EXPAND:  if (idx == 6'(NW - 1)) state_n = DONE;
            DONE:    if (start_edge) state_n = EXPAND;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            start_q <= 1'b0;
            armed   <= 1'b0;
            for (int j = 0; j < NW; j++) begin
                w[j] <= '0;
            end
        end else begin
            start_q <= start_i;
            if (!start_i) begin
                armed <= 1'b1;
            end
            if (load) begin
                for (int j = 0; j < NK; j++) begin
                    w[j] <= key_i[255 - 32*j -: 32];
                end
                idx <= 6'(NK);
            end else if (state == EXPAND) begin
                w[idx] <= new_word;
                idx    <= idx + 6'd1;
            end
        end
    end

    assign busy_o         = (state == EXPAND);
    assign key_exp_done_o = (state == DONE);
    assign rk_base        = {round_num_i, 2'b00};

    always_comb begin
        round_key_o = '0;
        if (state == DONE && round_num_i <= 4'(NR)) begin
            round_key_o = {w[rk_base],
                           w[rk_base + 6'd1],
                           w[rk_base + 6'd2],
                           w[rk_base + 6'd3]};
        end
    end

endmodule

// File: tb/tb_aes256_key_expansion.sv
// Scoreboard bench: a GF(2^8)-derived reference schedule feeds a
// queue of expected round keys, drained once done is reported.
module tb_aes256_key_expansion;

    logic         clk;
    logic         rst;
    logic         start_i;
    logic [255:0] key_i;
    logic [3:0]   round_num_i;
    logic         key_exp_done_o;
    logic         busy_o;
    logic [127:0] round_key_o;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;

    logic [7:0]   sb [256];
    logic [31:0]  sched [60];
    logic [127:0] exp_q [$];

    localparam logic [255:0] KA =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KB =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    aes256_key_expansion dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .key_i          (key_i),
        .round_num_i    (round_num_i),
        .key_exp_done_o (key_exp_done_o),
        .busy_o         (busy_o),
        .round_key_o    (round_key_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2)
                  ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] v);
        return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
    endfunction

    task automatic push_sched(input logic [255:0] k);
        logic [31:0] t;
        for (int i = 0; i < 8; i++) sched[i] = k[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = sched[i-1];
            if (i % 8 == 0)
                t = subw({t[23:0], t[31:24]})
                  ^ {8'h01 << (i/8 - 1), 24'h0};
            else if (i % 8 == 4)
                t = subw(t);
            sched[i] = sched[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++)
            exp_q.push_back({sched[4*r], sched[4*r+1],
                             sched[4*r+2], sched[4*r+3]});
    endtask

    task automatic do_start(input logic [255:0] k, input bit hold,
                            input bit push, input string tag);
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        key_i   = k;
        start_i = 1'b1;
        if (push) push_sched(k);
        @(posedge clk);
        #1;
        check({tag, "_busy_at_start"}, 128'(busy_o), 128'd1);
        check({tag, "_done_at_start"}, 128'(key_exp_done_o), 128'd0);
        key_i = ~k;
        if (!hold) start_i = 1'b0;
    endtask

    task automatic wait_done(input int inj_start, input int inj_rst,
                             input string tag, output int l);
        l = -1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (c == 51) begin
                check({tag, "_busy_c51"}, 128'(busy_o), 128'd1);
                check({tag, "_done_c51"}, 128'(key_exp_done_o), 128'd0);
            end
            if (c == inj_start) begin
                key_i   = KA;
                start_i = 1'b1;
            end
            if (c == inj_start + 1) start_i = 1'b0;
            if (c == inj_rst) begin
                rst     = 1'b1;
                start_i = 1'b1;
                #1;
                check({tag, "_rst_done"}, 128'(key_exp_done_o), 128'd0);
                check({tag, "_rst_busy"}, 128'(busy_o), 128'd0);
                for (int r = 0; r < 16; r++) begin
                    round_num_i = 4'(r);
                    #1;
                    check({tag, "_rst_rk"}, round_key_o, 128'd0);
                end
                exp_q.delete();
                l = 0;
                return;
            end
            if (key_exp_done_o) begin
                l = c;
                return;
            end
        end
        check({tag, "_done_timeout"}, 128'd0, 128'd1);
    endtask

    task automatic check_keys(input string tag);
        logic [127:0] e;
        for (int r = 0; r < 15; r++) begin
            round_num_i = 4'(r);
            #1;
            if (exp_q.size() == 0) begin
                check({tag, "_queue_empty"}, 128'd0, 128'd1);
                return;
            end
            e = exp_q.pop_front();
            check($sformatf("%s_rk%0d", tag, r), round_key_o, e);
        end
    endtask

    initial begin
        rst         = 1'b1;
        start_i     = 1'b0;
        key_i       = '0;
        round_num_i = '0;
        build_sbox();
        repeat (3) @(posedge clk);
        #1;
        check("reset_done", 128'(key_exp_done_o), 128'd0);
        check("reset_busy", 128'(busy_o), 128'd0);
        check("reset_rk", round_key_o, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        do_start(KA, 1'b0, 1'b1, "t1");
        wait_done(0, 0, "t1", lat);
        check("t1_latency", 128'(lat), 128'd52);
        check_keys("t1");
        round_num_i = 4'd0;
        #1 check("t1_r0_key_hi", round_key_o, KA[255:128]);
        round_num_i = 4'd1;
        #1 check("t1_r1", round_key_o,
                 128'h101112131415161718191a1b1c1d1e1f);
        round_num_i = 4'd2;
        #1 check("t1_r2", round_key_o,
                 128'ha573c29fa176c498a97fce93a572c09c);
        round_num_i = 4'd14;
        #1 check("t1_r14", round_key_o,
                 128'h24fc79ccbf0979e9371ac23c6d68de36);
        round_num_i = 4'd15;
        #1 check("t1_r15_zero", round_key_o, 128'd0);

        do_start(KB, 1'b1, 1'b1, "t2");
        wait_done(0, 0, "t2", lat);
        check("t2_latency", 128'(lat), 128'd52);
        round_num_i = 4'd2;
        #1 check("t2_w8", 128'(round_key_o[127:96]), 128'h9ba35411);
        check_keys("t2");
        repeat (146) @(posedge clk);
        #1;
        check("t2_hold_busy", 128'(busy_o), 128'd0);
        check("t2_hold_done", 128'(key_exp_done_o), 128'd1);

        do_start(KA, 1'b0, 1'b1, "t3");
        wait_done(0, 0, "t3", lat);
        check("t3_latency", 128'(lat), 128'd52);
        check_keys("t3");

        do_start(KB, 1'b0, 1'b1, "t4");
        wait_done(20, 0, "t4", lat);
        check("t4_latency", 128'(lat), 128'd52);
        check_keys("t4");

        do_start(KA, 1'b0, 1'b1, "t5");
        wait_done(0, 30, "t5", lat);
        @(negedge clk);
        rst = 1'b0;
        round_num_i = 4'd0;
        repeat (60) @(posedge clk);
        #1;
        check("t5_no_retrigger_busy", 128'(busy_o), 128'd0);
        check("t5_no_retrigger_done", 128'(key_exp_done_o), 128'd0);
        check("t5_no_retrigger_rk", round_key_o, 128'd0);

        do_start(KB, 1'b0, 1'b1, "t6");
        wait_done(0, 0, "t6", lat);
        check("t6_latency", 128'(lat), 128'd52);
        check_keys("t6");
        check("queue_drained", 128'(exp_q.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
